// File: rtl/code_defs_pkg.sv
// Shared 64b/66b code definitions: sync-header encodings and BER monitor state type.
package code_defs_pkg;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTL  = 2'b10;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_TEST   = 2'd1,
        ST_HI_BER = 2'd2
    } ber_state_t;

    // A qualified header that is neither data nor control is a sync error.
    function automatic logic hdr_invalid(input logic valid, input logic [1:0] hdr);
        return valid && (hdr != SYNC_DATA) && (hdr != SYNC_CTL);
    endfunction

endpackage

// File: rtl/ber_monitor.sv
// High bit-error-rate monitor: counts invalid sync headers per fixed window,
// raises o_hi_ber at threshold and keeps a saturating management error count.
module ber_monitor
    import code_defs_pkg::*;
#(
    parameter int TIMER_CYCLES  = 40283,
    parameter int BER_THRESHOLD = 16,
    parameter int CNT_WIDTH     = 6
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic [1:0]           i_header,
    input  logic                 i_valid,
    input  logic                 i_block_lock,
    input  logic                 i_ber_cnt_clr,
    output logic                 o_hi_ber,
    output logic [CNT_WIDTH-1:0] o_ber_cnt,
    output logic                 o_window_tick
);

    localparam int TW = $clog2(TIMER_CYCLES);
    localparam int WW = $clog2(BER_THRESHOLD + 1);
    localparam logic [TW-1:0]        TIMER_LAST = TW'(TIMER_CYCLES - 1);
    localparam logic [WW:0]          THRESH     = (WW + 1)'(BER_THRESHOLD);
    localparam logic [WW-1:0]        THRESH_W   = WW'(BER_THRESHOLD);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

    ber_state_t     state, state_nxt;
    logic [TW-1:0]  timer, timer_nxt;
    logic [WW-1:0]  win_cnt, win_nxt;
    logic [WW:0]    win_sum;
    logic           hi_ber_nxt, tick_nxt;
    logic           bad, win_end, over;

    assign bad     = hdr_invalid(i_valid, i_header);
    assign win_end = (state != ST_INIT) && (timer == TIMER_LAST);
    assign win_sum = {1'b0, win_cnt} + {{WW{1'b0}}, bad};
    // Threshold check includes the current header, so a hit on the window-end
    // cycle still lands in the closing window.
    assign over    = (state == ST_TEST) && (win_sum >= THRESH);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= ST_INIT;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!i_block_lock) begin
            state_nxt = ST_INIT;
        end else begin
            case (state)
                ST_INIT:   state_nxt = ST_TEST;
                ST_TEST:   if (over) state_nxt = ST_HI_BER;
                ST_HI_BER: if (win_end) state_nxt = ST_TEST;
                default:   state_nxt = ST_INIT;
            endcase
        end
    end

    always_comb begin
        timer_nxt  = '0;
        win_nxt    = '0;
        hi_ber_nxt = 1'b0;
        if (i_block_lock) begin
            case (state)
                ST_TEST: begin
                    timer_nxt  = win_end ? '0 : timer + TW'(1);
                    win_nxt    = win_end ? '0 : (over ? THRESH_W : win_sum[WW-1:0]);
                    hi_ber_nxt = over ? 1'b1 : (win_end ? 1'b0 : o_hi_ber);
                end
                ST_HI_BER: begin
                    timer_nxt  = win_end ? '0 : timer + TW'(1);
                    win_nxt    = win_end ? '0 : win_cnt;
                    hi_ber_nxt = 1'b1;
                end
                default: ;
            endcase
        end
        tick_nxt = (timer_nxt == TIMER_LAST);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            timer         <= '0;
            win_cnt       <= '0;
            o_hi_ber      <= 1'b0;
            o_window_tick <= 1'b0;
        end else begin
            timer         <= timer_nxt;
            win_cnt       <= win_nxt;
            o_hi_ber      <= hi_ber_nxt;
            o_window_tick <= tick_nxt;
        end
    end

    // Management count runs in every state while locked; a clear that
    // coincides with an error keeps that error.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_ber_cnt <= '0;
        end else if (i_ber_cnt_clr) begin
            o_ber_cnt <= {{(CNT_WIDTH - 1){1'b0}}, bad && i_block_lock};
        end else if (bad && i_block_lock && (o_ber_cnt != CNT_MAX)) begin
            o_ber_cnt <= o_ber_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_ber_monitor.sv
// Directed + randomized bench for ber_monitor against a window-level reference model.
module tb_ber_monitor;

    localparam int T    = 64;
    localparam int TH   = 16;
    localparam int CW   = 6;
    localparam int CMAX = 63;

    logic          i_clk = 1'b0;
    logic          i_reset_n = 1'b0;
    logic [1:0]    i_header = 2'b01;
    logic          i_valid = 1'b0;
    logic          i_block_lock = 1'b0;
    logic          i_ber_cnt_clr = 1'b0;
    logic          o_hi_ber;
    logic [CW-1:0] o_ber_cnt;
    logic          o_window_tick;

    int errors = 0;
    int checks = 0;

    // Reference model: position within the current window, errors seen in it,
    // whether counting is suspended until the window closes, and the status flags.
    bit m_run, m_hi, m_sup, m_tick;
    int m_pos, m_err, m_bcnt;

    ber_monitor #(.TIMER_CYCLES(T), .BER_THRESHOLD(TH), .CNT_WIDTH(CW)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_header(i_header), .i_valid(i_valid),
        .i_block_lock(i_block_lock), .i_ber_cnt_clr(i_ber_cnt_clr),
        .o_hi_ber(o_hi_ber), .o_ber_cnt(o_ber_cnt), .o_window_tick(o_window_tick)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_hi = 0; m_sup = 0; m_tick = 0;
        m_pos = 0; m_err = 0; m_bcnt = 0;
    endtask

    task automatic model_step();
        bit inv, last;
        inv = i_valid && (i_header == 2'b00 || i_header == 2'b11);
        if (i_ber_cnt_clr) m_bcnt = (inv && i_block_lock) ? 1 : 0;
        else if (inv && i_block_lock && m_bcnt < CMAX) m_bcnt++;
        if (!i_block_lock) begin
            m_run = 0; m_pos = 0; m_err = 0; m_hi = 0; m_sup = 0;
        end else if (!m_run) begin
            m_run = 1; m_pos = 0; m_err = 0;
        end else begin
            last = (m_pos == T - 1);
            if (!m_sup) begin
                if (inv && m_err < TH) m_err++;
                if (m_err >= TH) begin m_hi = 1; m_sup = 1; end
                else if (last) m_hi = 0;
            end else if (last) begin
                m_sup = 0;
            end
            if (last) begin m_err = 0; m_pos = 0; end
            else m_pos++;
        end
        m_tick = m_run && (m_pos == T - 1);
    endtask

    task automatic step();
        @(posedge i_clk);
        model_step();
        #1;
        chk("hi_ber", o_hi_ber, m_hi);
        chk("ber_cnt", o_ber_cnt, m_bcnt);
        chk("window_tick", o_window_tick, m_tick);
    endtask

    task automatic drive(input bit bad);
        i_valid = 1'b1;
        if (bad) i_header = ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11;
        else     i_header = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
    endtask

    task automatic idle();
        i_valid  = 1'b0;
        i_header = 2'($urandom_range(0, 3));
    endtask

    // Step until the model says the current cycle is the last of a window.
    task automatic run_to_tick();
        int n;
        n = 0;
        idle();
        while (!m_tick && n < 4 * T) begin step(); n++; end
        if (!m_tick) begin
            checks++; errors++;
            $error("FAIL run_to_tick timeout observed=%0d expected<%0d", n, 4 * T);
        end
    endtask

    task automatic align();
        run_to_tick();
        step();
    endtask

    initial begin
        int n;
        model_reset();
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_hi_ber", o_hi_ber, 0);
        chk("rst_ber_cnt", o_ber_cnt, 0);
        chk("rst_tick", o_window_tick, 0);

        i_reset_n = 1'b1;
        i_block_lock = 1'b1;
        idle();
        step();

        // 15 errors in one window: no hi_ber.
        align();
        for (int i = 0; i < 15; i++) begin drive(1); step(); end
        run_to_tick();
        step();
        chk("cnt_15", o_ber_cnt, 15);
        chk("hi_15", o_hi_ber, 0);

        // 16 errors: set, held across the next boundary, cleared after a clean window.
        align();
        for (int i = 0; i < 16; i++) begin
            drive(1); step();
            if (i == 14) chk("hi_before_16th", o_hi_ber, 0);
        end
        chk("hi_after_16th", o_hi_ber, 1);
        run_to_tick();
        chk("hi_end_A", o_hi_ber, 1);
        step();
        chk("hi_held_B", o_hi_ber, 1);
        run_to_tick();
        chk("hi_end_B", o_hi_ber, 1);
        step();
        chk("hi_cleared", o_hi_ber, 0);

        // 16th error on the window-end cycle.
        for (int i = 0; i < 15; i++) begin drive(1); step(); end
        run_to_tick();
        chk("tick_before_16th", o_window_tick, 1);
        drive(1);
        step();
        chk("hi_tick_entry", o_hi_ber, 1);
        run_to_tick();
        step();
        chk("hi_no_clear", o_hi_ber, 1);

        // One unlocked cycle drops hi_ber and restarts the window timer.
        idle();
        i_block_lock = 1'b0;
        step();
        chk("hi_unlock", o_hi_ber, 0);
        i_block_lock = 1'b1;
        n = 0;
        do begin step(); n++; end while (!o_window_tick && n < 4 * T);
        chk("restart_len", n, T);

        // Saturation and clear behaviour.
        i_ber_cnt_clr = 1'b1; idle(); step();
        i_ber_cnt_clr = 1'b0;
        chk("clr_alone", o_ber_cnt, 0);
        for (int i = 0; i < 70; i++) begin drive(1); step(); end
        chk("cnt_sat", o_ber_cnt, CMAX);
        i_ber_cnt_clr = 1'b1; drive(1); step();
        chk("clr_with_err", o_ber_cnt, 1);
        idle(); step();
        i_ber_cnt_clr = 1'b0;
        chk("clr_again", o_ber_cnt, 0);

        // Randomized traffic with occasional lock loss and clears.
        for (int i = 0; i < 1500; i++) begin
            i_block_lock  = ($urandom_range(0, 99) >= 2);
            i_ber_cnt_clr = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 1) != 0) drive($urandom_range(0, 9) < 4);
            else idle();
            step();
        end
        i_block_lock = 1'b1; i_ber_cnt_clr = 1'b0; idle();
        step(); step();

        // Asynchronous reset while in HI_BER, mid-window.
        align();
        for (int i = 0; i < 16; i++) begin drive(1); step(); end
        idle();
        repeat (5) step();
        chk("hi_pre_reset", o_hi_ber, 1);
        #3 i_reset_n = 1'b0;
        #1;
        chk("async_hi_ber", o_hi_ber, 0);
        chk("async_ber_cnt", o_ber_cnt, 0);
        chk("async_tick", o_window_tick, 0);
        model_reset();
        repeat (2) @(posedge i_clk);
        #1 i_reset_n = 1'b1;
        n = 0;
        do begin step(); n++; end while (!o_window_tick && n < 4 * T);
        chk("post_reset_len", n, T);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
